// File: rtl/display_seg_sequencer.sv
// Multi-frame segment sequencer: expands a captured seed into pairwise XOR bits
// one pair per cycle, then presents one registered segment frame per handshake.
module display_seg_sequencer #(
  parameter int NB_SEGMENTS = 28,
  parameter int RNDSIZE     = 9,
  parameter int NB_FRAMES   = 8,
  localparam int NPAIRS     = RNDSIZE * (RNDSIZE - 1) / 2,
  localparam int FW         = (NB_FRAMES > 1) ? $clog2(NB_FRAMES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NB_SEGMENTS-1:0] msg,
  input  logic                   z,
  input  logic [RNDSIZE-1:0]     seed,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_SEGMENTS-1:0] out_seg,
  output logic [FW-1:0]          out_frame,
  output logic                   done
);

  // Handshake: a frame transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid depends only on registered state.

  localparam int KW = $clog2(NPAIRS + 1);
  localparam int IW = $clog2(RNDSIZE);

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [NB_SEGMENTS-1:0] msg_q;
  logic                   z_q;
  logic [RNDSIZE-1:0]     seed_q;
  logic [FW:0]            frame_q;
  logic [IW-1:0]          i_q, j_q;
  logic [KW-1:0]          k_q;
  logic [NPAIRS-1:0]      rndx_q, rndx_d;
  logic [2*RNDSIZE-1:0]   dbl;
  logic [RNDSIZE-1:0]     r_f;
  logic [NB_SEGMENTS-1:0] seg_d;
  logic                   last_pair, last_frame;

  assign last_pair  = (k_q == KW'(NPAIRS - 1));
  assign last_frame = (frame_q == (FW+1)'(NB_FRAMES - 1));
  assign busy       = (state_q != IDLE);
  assign out_frame  = frame_q[FW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (last_pair) state_d = EMIT;
      EMIT:    if (out_ready) state_d = last_frame ? IDLE : EXPAND;
      default: state_d = IDLE;
    endcase
  end

  // Rotating a doubled copy left keeps the wrapped bits in the upper half.
  always_comb begin
    dbl            = {seed_q, seed_q} << (int'(frame_q) % RNDSIZE);
    r_f            = dbl[2*RNDSIZE-1:RNDSIZE];
    rndx_d         = rndx_q;
    rndx_d[k_q]    = r_f[i_q] ^ r_f[j_q];
    seg_d          = '0;
    for (int s = 0; s < NB_SEGMENTS; s++)
      seg_d[s] = msg_q[s] | (z_q & rndx_d[s % NPAIRS]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q     <= '0;
      z_q       <= 1'b0;
      seed_q    <= '0;
      frame_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rndx_q    <= '0;
      out_valid <= 1'b0;
      out_seg   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          msg_q   <= msg;
          z_q     <= z;
          seed_q  <= seed;
          frame_q <= '0;
          i_q     <= '0;
          j_q     <= IW'(1);
          k_q     <= '0;
        end
        EXPAND: begin
          rndx_q <= rndx_d;
          k_q    <= k_q + KW'(1);
          if (j_q == IW'(RNDSIZE - 1)) begin
            i_q <= i_q + IW'(1);
            j_q <= i_q + IW'(2);
          end else begin
            j_q <= j_q + IW'(1);
          end
          // The final pair feeds the frame directly so out_seg is registered.
          if (last_pair) begin
            out_valid <= 1'b1;
            out_seg   <= seg_d;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          out_seg   <= '0;
          i_q       <= '0;
          j_q       <= IW'(1);
          k_q       <= '0;
          if (last_frame) done <= 1'b1;
          else            frame_q <= frame_q + (FW+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_seg_sequencer.sv
// Directed bench for display_seg_sequencer: default build plus a small
// NB_FRAMES=1 / RNDSIZE=2 build sharing clock and reset.
module tb_display_seg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] msg = '0;
  logic        z = 1'b0;
  logic [8:0]  seed = '0;
  logic        busy, out_valid, done;
  logic        out_ready = 1'b1;
  logic [27:0] out_seg;
  logic [2:0]  out_frame;

  logic        start2 = 1'b0;
  logic [3:0]  msg2 = '0;
  logic        z2 = 1'b0;
  logic [1:0]  seed2 = '0;
  logic        busy2, valid2, done2;
  logic        ready2 = 1'b1;
  logic [3:0]  seg2;
  logic [0:0]  frame2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  display_seg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .z(z), .seed(seed),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_seg(out_seg), .out_frame(out_frame), .done(done)
  );

  display_seg_sequencer #(.NB_SEGMENTS(4), .RNDSIZE(2), .NB_FRAMES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .msg(msg2), .z(z2), .seed(seed2),
    .busy(busy2), .out_valid(valid2), .out_ready(ready2),
    .out_seg(seg2), .out_frame(frame2), .done(done2)
  );

  // Reference: rotate seed left by f mod 9, XOR every pair (i<j) in
  // lexicographic order, then OR the noise into the message.
  function automatic logic [27:0] model_seg(logic [27:0] m, logic zz, logic [8:0] sd, int f);
    logic [8:0]  r;
    logic [35:0] rnd;
    logic [27:0] seg;
    int k;
    for (int b = 0; b < 9; b++) r[b] = sd[(b - (f % 9) + 9) % 9];
    k = 0;
    for (int a = 0; a < 9; a++)
      for (int c = a + 1; c < 9; c++) begin
        rnd[k] = r[a] ^ r[c];
        k++;
      end
    for (int s = 0; s < 28; s++) seg[s] = m[s] | (zz & rnd[s % 36]);
    return seg;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [27:0] m, input logic zz, input logic [8:0] sd);
    msg = m; z = zz; seed = sd; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Edges from now until out_valid is seen; 200 means it never came.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    vectors++; if (out_seg !== 28'h0) begin miscompares++; $display("FAIL reset_seg got=%h exp=0", out_seg); end
    vectors++; if (out_frame !== 3'd0) begin miscompares++; $display("FAIL reset_frame got=%0d exp=0", out_frame); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if ({busy2, valid2, done2} !== 3'b000) begin miscompares++; $display("FAIL reset_dut2 got=%b exp=000", {busy2, valid2, done2}); end
    #2 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_seed_one;
    int n;
    do_start(28'h0, 1'b1, 9'h001);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL s1_busy got=%b exp=1", busy); end
    wait_valid(n);
    vectors++; if (n != 36) begin miscompares++; $display("FAIL s1_latency got=%0d exp=36", n); end
    vectors++; if (out_seg !== 28'h00000FF) begin miscompares++; $display("FAIL s1_f0_seg got=%h exp=00000ff", out_seg); end
    vectors++; if (out_frame !== 3'd0) begin miscompares++; $display("FAIL s1_f0_frame got=%0d exp=0", out_frame); end
    tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL s1_valid_drop got=%b exp=0", out_valid); end
    wait_valid(n);
    vectors++; if (n != 36) begin miscompares++; $display("FAIL s1_period got=%0d exp=36", n); end
    vectors++; if (out_seg !== 28'h0007F01) begin miscompares++; $display("FAIL s1_f1_seg got=%h exp=0007f01", out_seg); end
    vectors++; if (out_frame !== 3'd1) begin miscompares++; $display("FAIL s1_f1_frame got=%0d exp=1", out_frame); end
    for (int f = 2; f < 8; f++) begin
      tick;
      wait_valid(n);
      vectors++; if (out_seg !== model_seg(28'h0, 1'b1, 9'h001, f)) begin miscompares++; $display("FAIL s1_seg f=%0d got=%h exp=%h", f, out_seg, model_seg(28'h0, 1'b1, 9'h001, f)); end
      vectors++; if (out_frame !== 3'(f)) begin miscompares++; $display("FAIL s1_frame got=%0d exp=%0d", out_frame, f); end
    end
    tick;
    vectors++; if ({done, busy, out_valid} !== 3'b100) begin miscompares++; $display("FAIL s1_done got=%b exp=100", {done, busy, out_valid}); end
    tick;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL s1_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_passthrough;
    int cyc, ef;
    do_start(28'h5A5A5A5, 1'b0, 9'h13B);
    cyc = 0; ef = 0;
    while (!done && cyc < 1000) begin
      if (out_valid) begin
        vectors++; if (out_seg !== 28'h5A5A5A5) begin miscompares++; $display("FAIL pt_seg got=%h exp=5a5a5a5", out_seg); end
        vectors++; if (out_frame !== 3'(ef)) begin miscompares++; $display("FAIL pt_frame got=%0d exp=%0d", out_frame, ef); end
        ef++;
      end
      tick;
      cyc++;
    end
    vectors++; if (cyc != 296) begin miscompares++; $display("FAIL pt_duration got=%0d exp=296", cyc); end
    vectors++; if (ef != 8) begin miscompares++; $display("FAIL pt_frames got=%0d exp=8", ef); end
    tick;
    vectors++; if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL pt_after_done got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_back_pressure;
    int n;
    do_start(28'h0000F00, 1'b1, 9'h0A5);
    for (int f = 0; f < 8; f++) begin
      wait_valid(n);
      vectors++; if (n != 36) begin miscompares++; $display("FAIL bp_latency f=%0d got=%0d exp=36", f, n); end
      vectors++; if (out_frame !== 3'(f)) begin miscompares++; $display("FAIL bp_frame got=%0d exp=%0d", out_frame, f); end
      vectors++; if (out_seg !== model_seg(28'h0000F00, 1'b1, 9'h0A5, f)) begin miscompares++; $display("FAIL bp_seg f=%0d got=%h exp=%h", f, out_seg, model_seg(28'h0000F00, 1'b1, 9'h0A5, f)); end
      if (f == 2) begin
        out_ready = 1'b0;
        repeat (10) begin
          tick;
          vectors++; if ({out_valid, out_frame} !== {1'b1, 3'd2}) begin miscompares++; $display("FAIL bp_hold got=%b/%0d exp=1/2", out_valid, out_frame); end
          vectors++; if (out_seg !== model_seg(28'h0000F00, 1'b1, 9'h0A5, 2)) begin miscompares++; $display("FAIL bp_hold_seg got=%h exp=%h", out_seg, model_seg(28'h0000F00, 1'b1, 9'h0A5, 2)); end
        end
        out_ready = 1'b1;
      end
      tick;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done got=%b exp=1", done); end
    tick;
  endtask

  task automatic test_start_ignored;
    int n;
    do_start(28'h0, 1'b1, 9'h001);
    repeat (5) tick;
    msg = 28'hFFFFFFF; z = 1'b0; seed = 9'h003; start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid(n);
    vectors++; if (n != 30) begin miscompares++; $display("FAIL ign_latency got=%0d exp=30", n); end
    vectors++; if (out_seg !== 28'h00000FF) begin miscompares++; $display("FAIL ign_f0_seg got=%h exp=00000ff", out_seg); end
    for (int f = 1; f < 8; f++) begin
      tick;
      wait_valid(n);
      vectors++; if (out_seg !== model_seg(28'h0, 1'b1, 9'h001, f)) begin miscompares++; $display("FAIL ign_seg f=%0d got=%h exp=%h", f, out_seg, model_seg(28'h0, 1'b1, 9'h001, f)); end
    end
    tick;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ign_done got=%b exp=1", done); end
    msg = 28'h1234567; z = 1'b1; seed = 9'h055; start = 1'b1;
    tick;
    start = 1'b0;
    vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL b2b_accept got=%b exp=10", {busy, done}); end
    wait_valid(n);
    vectors++; if (n != 36) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=36", n); end
    vectors++; if (out_seg !== model_seg(28'h1234567, 1'b1, 9'h055, 0)) begin miscompares++; $display("FAIL b2b_seg got=%h exp=%h", out_seg, model_seg(28'h1234567, 1'b1, 9'h055, 0)); end
  endtask

  task automatic test_abort;
    int n, dones;
    for (int f = 1; f < 4; f++) begin
      tick;
      wait_valid(n);
    end
    vectors++; if (out_frame !== 3'd3) begin miscompares++; $display("FAIL ab_at_frame got=%0d exp=3", out_frame); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({out_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL ab_drop got=%b exp=00", {out_valid, busy}); end
    vectors++; if (out_seg !== 28'h0) begin miscompares++; $display("FAIL ab_seg got=%h exp=0", out_seg); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      tick;
      if (done) dones++;
    end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL ab_no_done got=%0d exp=0", dones); end
    do_start(28'h0, 1'b1, 9'h001);
    wait_valid(n);
    vectors++; if (n != 36) begin miscompares++; $display("FAIL ab_restart_lat got=%0d exp=36", n); end
    vectors++; if ({out_frame, out_seg} !== {3'd0, 28'h00000FF}) begin miscompares++; $display("FAIL ab_restart got=%0d/%h exp=0/00000ff", out_frame, out_seg); end
    #2 rst_n = 1'b0;
    tick;
    #2 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_all_ones;
    int n;
    do_start(28'h0, 1'b1, 9'h1FF);
    for (int f = 0; f < 8; f++) begin
      wait_valid(n);
      vectors++; if ({out_frame, out_seg} !== {3'(f), 28'h0}) begin miscompares++; $display("FAIL ones f=%0d got=%0d/%h exp=%0d/0", f, out_frame, out_seg, f); end
      tick;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ones_done got=%b exp=1", done); end
    tick;
  endtask

  task automatic test_single_frame;
    logic [3:0] m_v [3];
    logic [1:0] s_v [3];
    logic       z_v [3];
    logic [3:0] e_v [3];
    m_v[0] = 4'b0000; s_v[0] = 2'b01; z_v[0] = 1'b1; e_v[0] = 4'b1111;
    m_v[1] = 4'b0100; s_v[1] = 2'b11; z_v[1] = 1'b1; e_v[1] = 4'b0100;
    m_v[2] = 4'b1010; s_v[2] = 2'b01; z_v[2] = 1'b0; e_v[2] = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      msg2 = m_v[t]; seed2 = s_v[t]; z2 = z_v[t]; start2 = 1'b1;
      tick;
      start2 = 1'b0;
      vectors++; if ({busy2, valid2} !== 2'b10) begin miscompares++; $display("FAIL sf_expand t=%0d got=%b exp=10", t, {busy2, valid2}); end
      tick;
      vectors++; if ({valid2, frame2, seg2} !== {1'b1, 1'b0, e_v[t]}) begin miscompares++; $display("FAIL sf_emit t=%0d got=%b/%0d/%b exp=1/0/%b", t, valid2, frame2, seg2, e_v[t]); end
      tick;
      vectors++; if ({done2, busy2, valid2} !== 3'b100) begin miscompares++; $display("FAIL sf_done t=%0d got=%b exp=100", t, {done2, busy2, valid2}); end
      tick;
      vectors++; if (done2 !== 1'b0) begin miscompares++; $display("FAIL sf_done_pulse t=%0d got=%b exp=0", t, done2); end
    end
  endtask

  initial begin
    test_reset;
    test_seed_one;
    test_passthrough;
    test_back_pressure;
    test_start_ignored;
    test_abort;
    test_all_ones;
    test_single_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_seg_sequencer.md
# display_seg_sequencer

Sequential, parametrised successor to the combinational display front end: expands a random seed into pairwise XOR bits, selects display segments from a message plus random noise, and streams one segment frame per handshake for NB_FRAMES frames. Each frame uses fresh randomness derived from the seed. The block sits between the key/seed source and the segment-to-pixel stage. It adds multi-frame sequencing, serial XOR expansion and ready/valid back-pressure.

## Interface
- NB_SEGMENTS, default 28: segments per frame (bitmap segment count).
- RNDSIZE, default 9: seed width; NPAIRS = RNDSIZE*(RNDSIZE-1)/2 (36 at default).
- NB_FRAMES, default 8: frames emitted per start; FW = max(1, clog2(NB_FRAMES)).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sequence; sampled only in IDLE.
- msg  in  NB_SEGMENTS  message segments; captured on accepted start.
- z  in  1  noise enable; captured on accepted start.
- seed  in  RNDSIZE  random seed; captured on accepted start.
- busy  out  1  high from the start-accept edge until the done edge.
- out_valid  out  1  frame available.
- out_ready  in  1  downstream accepts the frame.
- out_seg  out  NB_SEGMENTS  selected segments; 0 when out_valid=0.
- out_frame  out  FW  index of the current frame (0..NB_FRAMES-1).
- done  out  1  one-cycle pulse after the last frame is accepted.

## Operation
- States: IDLE, EXPAND, EMIT.
- IDLE: if start=1, capture msg, z and seed; frame:=0; pair counters (i,j):=(0,1), k:=0; go to EXPAND; busy:=1.
- Frame randomness: r_f = seed rotated left by (f mod RNDSIZE), computed from the captured seed and the frame counter.
- EXPAND: one pair per cycle. rndx[k] := r_f[i] ^ r_f[j], then k++ and j++. When j=RNDSIZE-1, i++ and j:=i+2.
- Pair order is lexicographic, so k(i,j) = i*(2*RNDSIZE-i-1)/2 + (j-i-1).
- After writing k=NPAIRS-1, go to EMIT.
- EMIT: out_valid=1, out_seg[s] = msg_q[s] | (z_q & rndx[s mod NPAIRS]), out_frame=frame.
- EMIT with out_ready=1 and frame<NB_FRAMES-1: frame++, counters reset, go to EXPAND.
- EMIT with out_ready=1 and frame=NB_FRAMES-1: go to IDLE, busy:=0, done:=1 for one cycle.
- out_valid=0 in all other cycles. out_seg, out_frame and rndx are fully registered; no combinational path from out_ready to out_valid.
- start while busy is ignored. Input changes after capture have no effect.
- Widths: k counter clog2(NPAIRS+1); frame counter FW+1 bits internally. Rotation amount is reduced mod RNDSIZE.

## Timing
- Reset (async assert, synchronous release): state=IDLE, busy=0, out_valid=0, out_seg=0, out_frame=0, done=0, rndx=0, all counters 0.
- Reset mid-sequence aborts immediately; no done pulse is generated.
- Latency: out_valid rises NPAIRS clocks after the start-sampling edge.
- Frame period with out_ready held high is NPAIRS+1 cycles. Full sequence takes NB_FRAMES*(NPAIRS+1) cycles from start edge to done edge.
- Back-pressure: while out_valid=1 and out_ready=0, out_seg and out_frame hold stable; no timeout.
- done is asserted on the same edge that clears busy. start may be accepted on the very next edge; the done cycle is spent in IDLE.
- NB_FRAMES=1: a single EMIT, then done.
- RNDSIZE=2: NPAIRS=1, and every segment uses rndx[0].

## Test plan
- Defaults; seed=9'h001, msg=0, z=1, ready=1 -> frame0 out_seg=28'h00000FF (rndx[0..7]=1), valid at start+36 cycles; frame1 out_seg=28'h0007F01.
- z=0, msg=28'h5A5A5A5, any seed -> every frame out_seg=28'h5A5A5A5; out_frame steps 0..7; done pulses once after 8*37 cycles.
- Back-pressure: hold ready=0 for 10 cycles on frame 2 -> out_seg and out_frame stable, valid stays high; sequence resumes with no frame skipped.
- start pulsed during EXPAND with different msg -> ignored; outputs still reflect the first capture; a second start on the edge after done -> accepted.
- rst_n low during EMIT of frame 3 -> out_valid, busy and out_seg drop to 0 immediately; no done pulse; a fresh start restarts from frame 0.
- seed=9'h1FF, z=1, msg=0 -> all rndx=0, out_seg=0 for every frame; NB_FRAMES=1 build -> exactly one frame, then done.
